// File: rtl/sat_core_sequencer.sv
// Run controller for one SAT engine: steps BCP, decision, conflict analysis and
// in-bin backtrack for a loaded bin, then reports SAT / UNSAT / ABORT for that bin.
module sat_core_sequencer #(
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_LVL    = 16,
  parameter int WIDTH_CNT    = 16,
  parameter int WATCHDOG     = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_core_i,
  input  logic                    abort_i,
  input  logic [WIDTH_CNT-1:0]    conflict_limit_i,
  output logic                    done_core_o,
  output logic [1:0]              result_o,
  output logic                    timeout_o,
  output logic                    apply_imply_o,
  input  logic                    done_imply_i,
  input  logic                    conflict_i,
  output logic                    start_decision_o,
  input  logic                    done_decision_i,
  input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
  input  logic                    all_c_is_sat_i,
  output logic                    apply_analyze_o,
  input  logic                    done_analyze_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i,
  output logic                    apply_bkt_cur_bin_o,
  input  logic                    done_bkt_cur_bin_i,
  input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_num_o,
  output logic [WIDTH_CNT-1:0]    conflict_cnt_o,
  output logic [WIDTH_CNT-1:0]    decision_cnt_o,
  output logic                    busy_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BCP  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_ANA  = 3'd3;
  localparam logic [2:0] S_BKT  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] RES_SAT   = 2'd1;
  localparam logic [1:0] RES_UNSAT = 2'd2;
  localparam logic [1:0] RES_ABORT = 2'd3;

  localparam logic [WIDTH_CNT-1:0] CNT_ONE = 1;
  localparam logic [WIDTH_CNT-1:0] CNT_MAX = '1;
  localparam logic [31:0]          WD_LAST = (WATCHDOG > 0) ? 32'(WATCHDOG - 1) : 32'd0;

  logic [2:0]              r_state;
  logic                    r_firstCycle;
  logic [31:0]             r_wdCnt;
  logic [WIDTH_CNT-1:0]    r_limit;

  logic [2:0]              w_nextState;
  logic [1:0]              w_nextResult;
  logic                    w_nextTimeout;
  logic [WIDTH_CNT-1:0]    w_nextConflictCnt;
  logic [WIDTH_CNT-1:0]    w_nextDecisionCnt;
  logic [WIDTH_BIN_ID-1:0] w_nextBkt;
  logic [WIDTH_CNT-1:0]    w_nextLimit;
  logic [WIDTH_CNT-1:0]    w_conflictInc;
  logic [WIDTH_CNT-1:0]    w_decisionInc;
  logic                    w_working;
  logic                    w_wdHit;
  logic                    w_stateChange;

  assign w_conflictInc = (conflict_cnt_o == CNT_MAX) ? conflict_cnt_o : conflict_cnt_o + CNT_ONE;
  assign w_decisionInc = (decision_cnt_o == CNT_MAX) ? decision_cnt_o : decision_cnt_o + CNT_ONE;
  assign w_working     = (r_state == S_BCP) || (r_state == S_DEC) ||
                         (r_state == S_ANA) || (r_state == S_BKT);
  assign w_wdHit       = (WATCHDOG != 0) && (r_wdCnt == WD_LAST);
  assign w_stateChange = (w_nextState != r_state);

  // Abort beats the watchdog, which beats any done input; done inputs are only
  // honoured once the request cycle of the current state has passed.
  always_comb begin
    w_nextState       = r_state;
    w_nextResult      = result_o;
    w_nextTimeout     = timeout_o;
    w_nextConflictCnt = conflict_cnt_o;
    w_nextDecisionCnt = decision_cnt_o;
    w_nextBkt         = bkt_bin_num_o;
    w_nextLimit       = r_limit;
    if (r_state == S_IDLE) begin
      if (start_core_i) begin
        w_nextState       = S_BCP;
        w_nextResult      = 2'd0;
        w_nextTimeout     = 1'b0;
        w_nextConflictCnt = '0;
        w_nextDecisionCnt = '0;
        w_nextLimit       = conflict_limit_i;
      end
    end else if (r_state == S_DONE) begin
      w_nextState = S_IDLE;
    end else if (w_working) begin
      if (abort_i) begin
        w_nextState  = S_DONE;
        w_nextResult = RES_ABORT;
      end else if (w_wdHit) begin
        w_nextState   = S_DONE;
        w_nextResult  = RES_ABORT;
        w_nextTimeout = 1'b1;
      end else if (!r_firstCycle) begin
        case (r_state)
          S_BCP: begin
            if (done_imply_i) begin
              if (conflict_i) begin
                w_nextConflictCnt = w_conflictInc;
                if ((r_limit != '0) && (w_conflictInc == r_limit)) begin
                  w_nextState  = S_DONE;
                  w_nextResult = RES_ABORT;
                end else begin
                  w_nextState = S_ANA;
                end
              end else if (all_c_is_sat_i) begin
                w_nextState  = S_DONE;
                w_nextResult = RES_SAT;
              end else begin
                w_nextState = S_DEC;
              end
            end
          end
          S_DEC: begin
            if (done_decision_i) begin
              w_nextDecisionCnt = w_decisionInc;
              if (all_c_is_sat_i) begin
                w_nextState  = S_DONE;
                w_nextResult = RES_SAT;
              end else begin
                w_nextState = S_BCP;
              end
            end
          end
          S_ANA: begin
            if (done_analyze_i) begin
              if ((bkt_bin_num_i != cur_bin_num_i) || (cur_lvl_i == '0)) begin
                w_nextState  = S_DONE;
                w_nextResult = RES_UNSAT;
                w_nextBkt    = bkt_bin_num_i;
              end else begin
                w_nextState = S_BKT;
              end
            end
          end
          S_BKT: begin
            if (done_bkt_cur_bin_i) w_nextState = S_BCP;
          end
          default: ;
        endcase
      end
    end else begin
      w_nextState = S_IDLE;
    end
  end

  // Request and done pulses are registered from the next state so they land in
  // the first cycle of the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state             <= S_IDLE;
      r_firstCycle        <= 1'b0;
      r_wdCnt             <= '0;
      r_limit             <= '0;
      done_core_o         <= 1'b0;
      result_o            <= 2'd0;
      timeout_o           <= 1'b0;
      apply_imply_o       <= 1'b0;
      start_decision_o    <= 1'b0;
      apply_analyze_o     <= 1'b0;
      apply_bkt_cur_bin_o <= 1'b0;
      bkt_bin_num_o       <= '0;
      conflict_cnt_o      <= '0;
      decision_cnt_o      <= '0;
      busy_o              <= 1'b0;
    end else begin
      r_state             <= w_nextState;
      r_firstCycle        <= w_stateChange;
      r_wdCnt             <= w_stateChange ? 32'd0 : r_wdCnt + 32'd1;
      r_limit             <= w_nextLimit;
      done_core_o         <= w_stateChange && (w_nextState == S_DONE);
      result_o            <= w_nextResult;
      timeout_o           <= w_nextTimeout;
      apply_imply_o       <= w_stateChange && (w_nextState == S_BCP);
      start_decision_o    <= w_stateChange && (w_nextState == S_DEC);
      apply_analyze_o     <= w_stateChange && (w_nextState == S_ANA);
      apply_bkt_cur_bin_o <= w_stateChange && (w_nextState == S_BKT);
      bkt_bin_num_o       <= w_nextBkt;
      conflict_cnt_o      <= w_nextConflictCnt;
      decision_cnt_o      <= w_nextDecisionCnt;
      busy_o              <= (w_nextState != S_IDLE);
    end
  end

endmodule

// File: doc/sat_core_sequencer.md
# sat_core_sequencer

Parametrised controller for one SAT engine: sequences BCP, decision, conflict analysis and in-bin backtrack after a bin is loaded, and returns a result code for the bin. It adds a per-run conflict budget, a per-phase watchdog, external abort, saturating statistics counters and a latched backtrack-target bin. It sits between the bin loader/scheduler and the imply, decision, analyze and backtrack units of the engine.

## Interface
- WIDTH_BIN_ID, 10, bin number width
- WIDTH_LVL, 16, decision level width
- WIDTH_CNT, 16, statistics/budget counter width
- WATCHDOG, 4096, max cycles in any working state; 0 disables
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-low; clock clk
- start_core_i  in  1  start a run (sampled only in IDLE)
- abort_i  in  1  external abort
- conflict_limit_i  in  WIDTH_CNT  conflicts allowed per run; 0 = unlimited; sampled at start
- done_core_o  out  1  one-cycle pulse at end of run
- result_o  out  2  0 none, 1 SAT, 2 UNSAT (backtrack leaves bin), 3 ABORT
- timeout_o  out  1  run ended by watchdog
- apply_imply_o / done_imply_i / conflict_i  out/in/in  1  BCP handshake
- start_decision_o / done_decision_i  out/in  1  decision handshake
- cur_lvl_i  in  WIDTH_LVL  current level (unused except level-0 check)
- all_c_is_sat_i  in  1  all clauses satisfied
- apply_analyze_o / done_analyze_i  out/in  1  analysis handshake
- bkt_bin_num_i  in  WIDTH_BIN_ID  target bin from analysis
- apply_bkt_cur_bin_o / done_bkt_cur_bin_i  out/in  1  in-bin backtrack handshake
- cur_bin_num_i  in  WIDTH_BIN_ID  bin being solved
- bkt_bin_num_o  out  WIDTH_BIN_ID  latched target bin on UNSAT
- conflict_cnt_o, decision_cnt_o  out  WIDTH_CNT  per-run saturating counters
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, BCP, DECISION, ANALYSIS, BKT, DONE. State and all outputs registered.
- IDLE: start_core_i -> BCP; clears counters, timeout_o, result_o, latches limit.
- BCP: done_imply_i&conflict_i -> conflict_cnt++; if limit!=0 and new count==limit -> DONE/ABORT, else ANALYSIS. done_imply_i&~conflict_i&all_c_is_sat_i -> DONE/SAT. done_imply_i otherwise -> DECISION.
- DECISION: done_decision_i -> decision_cnt++; all_c_is_sat_i -> DONE/SAT else BCP.
- ANALYSIS: done_analyze_i and (bkt_bin_num_i!=cur_bin_num_i or cur_lvl_i==0 with equal bin) -> DONE/UNSAT, bkt_bin_num_o <= bkt_bin_num_i; equal bin and cur_lvl_i!=0 -> BKT.
- BKT: done_bkt_cur_bin_i -> BCP.
- DONE: done_core_o=1 for this one cycle; -> IDLE. result_o, timeout_o, bkt_bin_num_o, counters hold until next start.
- Priority in working states: abort_i > watchdog > done inputs. abort_i -> DONE/ABORT. Watchdog: per-state cycle counter cleared on entry; reaching WATCHDOG -> DONE/ABORT, timeout_o=1.
- Counters saturate at all-ones; no wrap.
- start_core_i outside IDLE ignored. Reset mid-run: next cycle IDLE, all outputs 0.

## Timing
- Reset values: all outputs 0, bkt_bin_num_o 0, state IDLE.
- Request outputs (apply_imply_o, start_decision_o, apply_analyze_o, apply_bkt_cur_bin_o) are exactly one-cycle pulses in the first cycle of the corresponding state (registered from next-state); never re-issued while state unchanged.
- done_* inputs ignored in the request cycle; accepted from the second cycle of the state on; done for a state not current is ignored.
- start at edge N -> BCP and apply_imply_o high in cycle N+1. Minimum BCP-to-DONE: done_imply_i in cycle N+2 -> DONE in N+3, done_core_o in N+3, result_o valid N+3.
- Watchdog: ABORT when state has lasted WATCHDOG cycles without accepted done.

## Test plan
- start, done_imply (no conflict, all_sat=1) 2 cycles later -> done_core_o pulse, result_o=1, counters 0.
- BCP, DECISION, BCP conflict, ANALYSIS bkt_bin=cur, lvl=3, BKT, BCP all_sat -> result_o=1, conflict_cnt_o=1, decision_cnt_o=1, each apply pulse exactly 1 cycle.
- Conflict with bkt_bin_num_i=5, cur_bin=2 -> result_o=2, bkt_bin_num_o=5; repeat with equal bin, lvl=0 -> result_o=2.
- conflict_limit_i=3, every BCP conflicts, analysis returns current bin lvl=1 -> ABORT on 3rd conflict, no 3rd apply_analyze_o, conflict_cnt_o=3.
- WATCHDOG=16, done_decision_i never -> ABORT 16 cycles after DECISION entry, timeout_o=1; abort_i with simultaneous done_imply_i -> ABORT.
- rst low mid-ANALYSIS -> next cycle all outputs 0, IDLE; start_core_i during BCP ignored.
